mem_bus_arbiter: RTL and testbench

- Shares a single main-memory port between the instruction-cache refill path (read-only) and the data-cache refill/write-back path (read/write).
- Serialises requests, forwards one transaction at a time to memory and returns data to the granted requester.
- Stalls the non-granted requester via its BUSYWAIT line.
- Sits between the two cache controllers and data/instruction main memory. Provides round-robin fairness and a memory-hang watchdog.

---
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache refill and D-cache refill/write-back.
// Min 3 cycles request to BUSYWAIT low; non-granted side stalls on BUSYWAIT; memory hangs trip a sticky ERR.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic              ERR
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [2:0] {IDLE, I_ACC, D_ACC, I_DONE, D_DONE} state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]  i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;

  logic i_req, d_req, done_ok, timed_out;

  assign i_req = I_READ;
  assign d_req = D_READ | D_WRITE;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    done_ok      = 1'b0;
    timed_out    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req && (!d_req || last_grant_q == GRANT_D)) begin
          state_d     = I_ACC;
          mem_addr_d  = I_ADDRESS;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          cnt_d       = '0;
        end else if (d_req) begin
          // Write wins when both D strobes are (illegally) high.
          state_d     = D_ACC;
          mem_addr_d  = D_ADDRESS;
          mem_wdata_d = D_WRITEDATA;
          mem_write_d = D_WRITE;
          mem_read_d  = !D_WRITE;
          cnt_d       = '0;
        end
      end
      I_ACC, D_ACC: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Memory may not have raised busy yet in the first access cycle.
        done_ok   = (cnt_q != '0) && !MEM_BUSYWAIT;
        timed_out = (cnt_d == CNT_W'(TIMEOUT));
        if (done_ok || timed_out) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (!done_ok) err_d = 1'b1;
          if (state_q == I_ACC) begin
            if (done_ok) i_rdata_d = MEM_READDATA;
            last_grant_d = GRANT_I;
            state_d      = I_DONE;
          end else begin
            if (done_ok && mem_read_q) d_rdata_d = MEM_READDATA;
            last_grant_d = GRANT_D;
            state_d      = D_DONE;
          end
        end
      end
      I_DONE, D_DONE: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign I_BUSYWAIT    = i_req && (state_q != I_DONE);
  assign D_BUSYWAIT    = d_req && (state_q != D_DONE);
  assign I_READDATA    = i_rdata_q;
  assign D_READDATA    = d_rdata_q;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign ERR           = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: table of single-requester transactions plus
// hand-written reset, arbitration, throughput and watchdog sequences.
module tb_mem_bus_arbiter;

  logic         CLK, RESET;
  logic         I_READ, D_READ, D_WRITE, MEM_BUSYWAIT;
  logic [5:0]   I_ADDRESS, D_ADDRESS;
  logic [127:0] D_WRITEDATA, MEM_READDATA;
  logic [127:0] I_READDATA, D_READDATA, MEM_WRITEDATA;
  logic [5:0]   MEM_ADDRESS;
  logic         I_BUSYWAIT, D_BUSYWAIT, MEM_READ, MEM_WRITE, ERR;

  int checks = 0;
  int errors = 0;
  int mem_wait = 1;
  int mem_rem = 0;
  bit mem_active = 0;

  mem_bus_arbiter #(.ADDR_W(6), .DATA_W(128), .TIMEOUT(255)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .ERR(ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory model: busy for mem_wait cycles after it first sees a strobe.
  initial begin
    MEM_BUSYWAIT = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (!(MEM_READ || MEM_WRITE)) begin
        mem_active   = 0;
        MEM_BUSYWAIT = 1'b0;
      end else if (!mem_active) begin
        mem_active   = 1;
        mem_rem      = mem_wait;
        MEM_BUSYWAIT = (mem_rem > 0);
      end else begin
        if (mem_rem > 0) mem_rem--;
        MEM_BUSYWAIT = (mem_rem > 0);
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         is_d;
    logic         rd;
    logic         wr;
    logic [5:0]   addr;
    logic [127:0] wdata;
    int           wait_c;
    logic [127:0] mrdata;
    int           exp_lat;
    logic         exp_mr;
    logic         exp_mw;
    logic [127:0] exp_i;
    logic [127:0] exp_d;
  } vec_t;

  vec_t vecs[6];

  // Called and returns on a falling edge; request is dropped in the IDLE cycle after DONE.
  task automatic do_txn(input vec_t v, input logic exp_err, input string nm);
    int lat;
    bit done;
    mem_wait     = v.wait_c;
    MEM_READDATA = v.mrdata;
    if (v.is_d) begin
      D_READ = v.rd; D_WRITE = v.wr; D_ADDRESS = v.addr; D_WRITEDATA = v.wdata;
    end else begin
      I_READ = 1'b1; I_ADDRESS = v.addr;
    end
    lat  = 0;
    done = 0;
    while (!done && lat < 400) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        chk({nm, " mem_read"}, 128'(MEM_READ), 128'(v.exp_mr));
        chk({nm, " mem_write"}, 128'(MEM_WRITE), 128'(v.exp_mw));
        chk({nm, " mem_addr"}, 128'(MEM_ADDRESS), 128'(v.addr));
        if (v.is_d) chk({nm, " mem_wdata"}, MEM_WRITEDATA, v.wdata);
        chk({nm, " other_busy"}, 128'(v.is_d ? I_BUSYWAIT : D_BUSYWAIT), 128'(0));
      end
      if ((v.is_d ? D_BUSYWAIT : I_BUSYWAIT) == 1'b0) done = 1;
    end
    chk({nm, " latency"}, 128'(lat), 128'(v.exp_lat));
    chk({nm, " i_rdata"}, I_READDATA, v.exp_i);
    chk({nm, " d_rdata"}, D_READDATA, v.exp_d);
    chk({nm, " err"}, 128'(ERR), 128'(exp_err));
    @(negedge CLK);
    chk({nm, " busy_again"}, 128'(v.is_d ? D_BUSYWAIT : I_BUSYWAIT), 128'(1));
    chk({nm, " strobes_off"}, 128'({MEM_READ, MEM_WRITE}), 128'(0));
    I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
  endtask

  initial begin
    vec_t t;
    RESET = 1'b1; I_READ = 0; D_READ = 0; D_WRITE = 0;
    I_ADDRESS = '0; D_ADDRESS = '0; D_WRITEDATA = '0; MEM_READDATA = '0;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 6'h05, 128'h0, 5, {16{8'hA5}}, 7, 1'b1, 1'b0,
                {16{8'hA5}}, 128'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 6'h3F, 128'h1234, 2, 128'hDEAD, 4, 1'b0, 1'b1,
                {16{8'hA5}}, 128'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 6'h0A, 128'h0, 1, 128'hCAFE, 3, 1'b1, 1'b0,
                {16{8'hA5}}, 128'hCAFE};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 6'h11, 128'h77, 3, 128'hBEEF, 5, 1'b0, 1'b1,
                {16{8'hA5}}, 128'hCAFE};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 6'h00, 128'h0, 0, {16{8'h5A}}, 3, 1'b1, 1'b0,
                {16{8'h5A}}, 128'hCAFE};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 6'h20, {4{32'h0BADF00D}}, 4, 128'h5555, 6, 1'b0, 1'b1,
                {16{8'h5A}}, 128'hCAFE};

    // Reset state
    @(negedge CLK);
    chk("rst mem_read", 128'(MEM_READ), 128'(0));
    chk("rst mem_write", 128'(MEM_WRITE), 128'(0));
    chk("rst err", 128'(ERR), 128'(0));
    chk("rst i_busy", 128'(I_BUSYWAIT), 128'(0));
    chk("rst d_busy", 128'(D_BUSYWAIT), 128'(0));
    chk("rst i_rdata", I_READDATA, 128'h0);
    chk("rst d_rdata", D_READDATA, 128'h0);
    chk("rst mem_addr", 128'(MEM_ADDRESS), 128'(0));
    RESET = 1'b0;

    for (int i = 0; i < 6; i++) do_txn(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Reset during D_ACC abandons the transaction
    mem_wait = 5; D_READ = 1'b1; D_ADDRESS = 6'h15;
    @(negedge CLK);
    @(negedge CLK);
    chk("midrst pre mem_read", 128'(MEM_READ), 128'(1));
    RESET = 1'b1;
    @(negedge CLK);
    chk("midrst mem_read", 128'(MEM_READ), 128'(0));
    chk("midrst mem_write", 128'(MEM_WRITE), 128'(0));
    chk("midrst no_done", 128'(D_BUSYWAIT), 128'(1));
    chk("midrst d_rdata", D_READDATA, 128'h0);
    chk("midrst i_rdata", I_READDATA, 128'h0);
    RESET = 1'b0; D_READ = 1'b0;

    // Simultaneous requests after reset alternate I,D,I,D
    mem_wait = 1; MEM_READDATA = 128'h44;
    I_ADDRESS = 6'h11; D_ADDRESS = 6'h22; I_READ = 1'b1; D_READ = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge CLK);
      if (c % 4 == 1)
        chk($sformatf("rr grant%0d addr", c / 4), 128'(MEM_ADDRESS),
            128'(((c / 4) % 2 == 0) ? 6'h11 : 6'h22));
      if (c % 4 == 3) begin
        chk($sformatf("rr done%0d i_busy", c / 4), 128'(I_BUSYWAIT),
            128'(((c / 4) % 2 == 0) ? 1'b0 : 1'b1));
        chk($sformatf("rr done%0d d_busy", c / 4), 128'(D_BUSYWAIT),
            128'(((c / 4) % 2 == 0) ? 1'b1 : 1'b0));
      end
      if (c == 1 || c == 2) chk("rr d_stalled", 128'(D_BUSYWAIT), 128'(1));
    end
    I_READ = 1'b0; D_READ = 1'b0;
    chk("rr d_rdata", D_READDATA, 128'h44);

    // Zero-wait memory with I held: one completion every 4 cycles
    mem_wait = 1; MEM_READDATA = 128'h66; I_ADDRESS = 6'h01; I_READ = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      chk($sformatf("tput c%0d i_busy", c), 128'(I_BUSYWAIT), 128'((c % 4 == 3) ? 1'b0 : 1'b1));
    end
    I_READ = 1'b0;
    chk("tput i_rdata", I_READDATA, 128'h66);

    // Hung memory: forced completion after 255 access cycles, data untouched
    t = '{1'b0, 1'b1, 1'b0, 6'h07, 128'h0, 100000, 128'h99, 256, 1'b1, 1'b0,
          128'h66, 128'h44};
    do_txn(t, 1'b1, "timeout");
    t = '{1'b0, 1'b1, 1'b0, 6'h09, 128'h0, 1, 128'h12, 3, 1'b1, 1'b0,
          128'h12, 128'h44};
    do_txn(t, 1'b1, "post_timeout");

    RESET = 1'b1;
    @(negedge CLK);
    chk("err cleared", 128'(ERR), 128'(0));
    RESET = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
